tv_stream_checker: RTL and testbench
====================================

Name: tv_stream_checker

Overview:
- Synthesizable self-check engine that sits between a vector store and the combinational unit under test. It streams stored {inputs, expected} vectors into that unit one at a time and compares the unit's output against the expected value.
- It counts vectors and mismatches and stops at a sentinel entry or at the end of memory.
- This is the hardware counterpart of the team's file-driven benches, so on-board runs report pass/fail without a simulator.

Parameters:
- DEPTH, 16: number of vector entries.
- AW, 4: address width; clog2(DEPTH).
- IN_W, 3: width of the DUT input bundle.
- OUT_W, 1: width of the DUT output.
- SETTLE, 1: wait cycles between driving the inputs and sampling the output (0 allowed).

Ports:
- clk in 1: single clock, rising edge.
- reset in 1: asynchronous, active-low. All state registers clear immediately while it is low; the vector memory is not reset.
- wr_en in 1: write strobe for the vector memory.
- wr_addr in AW: write address.
- wr_data in 1+IN_W+OUT_W: {valid, inputs, expected}, MSB first.
- start in 1: one-cycle run request.
- dut_out in OUT_W: combinational output of the DUT.
- dut_in out IN_W: registered inputs driven to the DUT.
- busy out 1: high while a run is in progress.
- done out 1: high in DONE, held until the next start or reset.
- pass out 1: done && err_count==0.
- vec_count out AW+1: number of vectors checked.
- err_count out AW+1: number of mismatches.
- err_valid out 1: one-cycle pulse on each mismatch.
- err_index out AW: index of the most recent mismatch.

Behaviour:
- Reset values: all outputs 0, state IDLE, idx 0.
- Memory writes:
  - Synchronous, accepted only when busy==0; writes while busy are ignored.
  - An entry whose valid bit is 0 is the sentinel and marks the end of the list.
- State machine:
  - IDLE/DONE: start==1 → clear vec_count, err_count, err_index, done and idx; go to FETCH. busy=1 from the next cycle.
  - FETCH: rd_q <= mem[idx] (registered read); go to APPLY.
  - APPLY, sentinel (rd_q.valid==0): go to DONE. dut_in holds its last value.
  - APPLY, valid entry: dut_in <= rd_q.inputs, cnt <= SETTLE, go to WAIT. If SETTLE==0, go directly to CHECK.
  - WAIT: decrement cnt each cycle; when cnt reaches 1, go to CHECK. WAIT occupies exactly SETTLE cycles.
  - CHECK: compare dut_out against rd_q.expected using 2-state equality (X/Z count as mismatch in simulation).
    - On mismatch: err_count+1, err_index<=idx, err_valid=1 for this cycle only.
    - Always: vec_count+1.
    - If idx==DEPTH-1, go to DONE; otherwise idx+1 and go to FETCH.
  - DONE: busy=0, done=1.
- Timing:
  - Each vector costs 3+SETTLE cycles.
  - A sentinel costs 2 cycles (FETCH, APPLY).
  - With N valid vectors before a sentinel, done rises 1+N*(3+SETTLE)+2 cycles after the start-sampling edge, counting the IDLE→FETCH edge.
  - A full memory with no sentinel finishes after the CHECK of entry DEPTH-1, with no wrap-around.
- Boundaries:
  - start while busy: ignored.
  - Sentinel at entry 0: done with vec_count 0, pass=1.
  - Counters cannot overflow: AW+1 bits hold DEPTH.
  - reset low mid-run: outputs clear immediately and state returns to IDLE. Memory keeps its contents, so a new start reruns the list.
- All outputs are registered.

Test Plan:
- Load the 8-row truth table of the 3-input DUT (valid=1, correct expected values) at addresses 0–7, sentinel at 8, SETTLE=1, pulse start → done rises 35 cycles after the start edge, vec_count=8, err_count=0, pass=1, err_valid never pulses.
- Same table with the expected bit of entry 5 inverted → exactly one err_valid pulse, err_index=5, err_count=1, pass=0, vec_count=8.
- Sentinel at address 0 → done rises 3 cycles after start, vec_count=0, pass=1, dut_in stays 0.
- All 16 entries valid, no sentinel → vec_count=16, done rises 1+16*4=65 cycles after start, and no read beyond address 15.
- During a run: pulse start and write address 3 → neither affects the run. Then drop reset mid-run → all outputs 0 immediately. Release reset and start again → identical results to the first run.
- SETTLE=0 variant with the 8-vector table → done rises 1+8*3+2=27 cycles after start, results identical to the first scenario.

Source files
------------

// File: rtl/tv_stream_checker.sv
// Streams stored {valid, inputs, expected} vectors into a combinational unit and
// checks each response; counts vectors/mismatches, stops at a sentinel or end of memory.
module tv_stream_checker #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [IN_W+OUT_W:0]   wr_data,
    input  logic                  start,
    input  logic [OUT_W-1:0]      dut_out,
    output logic [IN_W-1:0]       dut_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [AW:0]           vec_count,
    output logic [AW:0]           err_count,
    output logic                  err_valid,
    output logic [AW-1:0]         err_index
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    typedef struct packed {
        logic             valid;
        logic [IN_W-1:0]  inputs;
        logic [OUT_W-1:0] expected;
    } entry_t;

    typedef enum logic [2:0] {IDLE, FETCH, APPLY, WAIT, CHECK, DONE} state_t;

    entry_t         mem [DEPTH];
    entry_t         rd_q;
    state_t         state;
    logic [AW-1:0]  idx;
    logic [CW-1:0]  cnt;
    logic           mismatch;
    logic           last;

    // X/Z on the unit output must fail the vector, hence the case inequality
    assign mismatch = (dut_out !== rd_q.expected);
    assign last     = (idx == AW'(DEPTH - 1));

    // Vector store has no reset so contents survive a mid-run reset
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rd_q      <= '0;
            idx       <= '0;
            cnt       <= '0;
            dut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            vec_count <= '0;
            err_count <= '0;
            err_valid <= 1'b0;
            err_index <= '0;
        end else begin
            err_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec_count <= '0;
                        err_count <= '0;
                        err_index <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    rd_q  <= mem[idx];
                    state <= APPLY;
                end
                APPLY: begin
                    if (!rd_q.valid) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                        state <= DONE;
                    end else begin
                        dut_in <= rd_q.inputs;
                        cnt    <= CW'(SETTLE);
                        state  <= (SETTLE == 0) ? CHECK : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CW'(1))
                        state <= CHECK;
                end
                CHECK: begin
                    vec_count <= vec_count + 1'b1;
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        err_index <= idx;
                        err_valid <= 1'b1;
                    end
                    // No wrap-around: the last entry ends the run even without a sentinel
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tv_stream_checker.sv
// Directed bench: two checkers (SETTLE=1 and SETTLE=0) driving a 3-input majority unit.
module tb_tv_stream_checker;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en0, wr_en1, start0, start1;
    logic [3:0] wr_addr;
    logic [4:0] wr_data;
    logic [2:0] dut_in0, dut_in1;
    logic       dut_out0, dut_out1;
    logic       busy0, busy1, done0, done1, pass0, pass1, ev0, ev1;
    logic [4:0] vec0, vec1, err0, err1;
    logic [3:0] eidx0, eidx1;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc, evc;
    logic [7:0] maj_tbl;

    always #5 clk = ~clk;

    // Unit under test: 3-input majority
    assign dut_out1 = (dut_in1[0] & dut_in1[1]) | (dut_in1[0] & dut_in1[2]) | (dut_in1[1] & dut_in1[2]);
    assign dut_out0 = (dut_in0[0] & dut_in0[1]) | (dut_in0[0] & dut_in0[2]) | (dut_in0[1] & dut_in0[2]);

    tv_stream_checker #(.DEPTH(16), .AW(4), .IN_W(3), .OUT_W(1), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start1), .dut_out(dut_out1), .dut_in(dut_in1), .busy(busy1), .done(done1),
        .pass(pass1), .vec_count(vec1), .err_count(err1), .err_valid(ev1), .err_index(eidx1));

    tv_stream_checker #(.DEPTH(16), .AW(4), .IN_W(3), .OUT_W(1), .SETTLE(0)) u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start0), .dut_out(dut_out0), .dut_in(dut_in0), .busy(busy0), .done(done0),
        .pass(pass0), .vec_count(vec0), .err_count(err0), .err_valid(ev0), .err_index(eidx0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit to0, input bit to1, input int addr, input logic v,
                      input logic [2:0] in, input logic e);
        wr_en0  = to0;
        wr_en1  = to1;
        wr_addr = addr[3:0];
        wr_data = {v, in, e};
        @(posedge clk); #1;
        wr_en0 = 1'b0;
        wr_en1 = 1'b0;
    endtask

    // cyc counts edges from the start-sampling edge (inclusive) until done is seen
    task automatic run(input bit which, input int disturb, output int c, output int e);
        c = 0;
        e = 0;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        do begin
            @(posedge clk); c++; #1;
            start0 = 1'b0;
            start1 = 1'b0;
            wr_en1 = 1'b0;
            if (which ? ev1 : ev0) e++;
            if (disturb > 0 && c == disturb) begin
                start1  = 1'b1;
                wr_en1  = 1'b1;
                wr_addr = 4'd3;
                wr_data = {1'b1, 3'd3, 1'b0};
            end
        end while (!(which ? done1 : done0) && c < 200);
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, "_busy"}, busy1, 0);
        chk({tag, "_done"}, done1, 0);
        chk({tag, "_pass"}, pass1, 0);
        chk({tag, "_vec"},  vec1, 0);
        chk({tag, "_err"},  err1, 0);
        chk({tag, "_ev"},   ev1, 0);
        chk({tag, "_eidx"}, eidx1, 0);
        chk({tag, "_din"},  dut_in1, 0);
    endtask

    task automatic load_table(input int n);
        for (int i = 0; i < n; i++)
            wr(1'b1, 1'b1, i, 1'b1, i[2:0], maj_tbl[i[2:0]]);
    endtask

    initial begin
        maj_tbl = 8'b1110_1000;
        reset = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
        wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero1("rst");
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Correct 8-row table, sentinel at 8
        load_table(8);
        wr(1'b1, 1'b1, 8, 1'b0, 3'd0, 1'b0);
        run(1'b1, 0, cyc, evc);
        chk("s1_cyc", cyc, 35);
        chk("s1_vec", vec1, 8);
        chk("s1_err", err1, 0);
        chk("s1_pass", pass1, 1);
        chk("s1_done", done1, 1);
        chk("s1_busy", busy1, 0);
        chk("s1_ev", evc, 0);
        chk("s1_din", dut_in1, 7);
        repeat (3) @(posedge clk);
        #1 chk("s1_done_hold", done1, 1);

        // Entry 5 expected bit inverted
        wr(1'b1, 1'b1, 5, 1'b1, 3'd5, ~maj_tbl[5]);
        run(1'b1, 0, cyc, evc);
        chk("s2_cyc", cyc, 35);
        chk("s2_ev", evc, 1);
        chk("s2_eidx", eidx1, 5);
        chk("s2_err", err1, 1);
        chk("s2_pass", pass1, 0);
        chk("s2_vec", vec1, 8);

        // Reset pulse clears a finished run
        reset = 1'b0;
        #1 chk_zero1("rst2");
        @(posedge clk); #1 reset = 1'b1;

        // Sentinel at entry 0
        wr(1'b1, 1'b1, 0, 1'b0, 3'd6, 1'b1);
        run(1'b1, 0, cyc, evc);
        chk("s3_cyc", cyc, 3);
        chk("s3_vec", vec1, 0);
        chk("s3_pass", pass1, 1);
        chk("s3_done", done1, 1);
        chk("s3_din", dut_in1, 0);

        // Full memory, no sentinel
        load_table(16);
        run(1'b1, 0, cyc, evc);
        chk("s4_cyc", cyc, 65);
        chk("s4_vec", vec1, 16);
        chk("s4_err", err1, 0);
        chk("s4_pass", pass1, 1);
        chk("s4_din", dut_in1, 7);

        // Start and write while busy are ignored
        wr(1'b1, 1'b1, 8, 1'b0, 3'd0, 1'b0);
        run(1'b1, 5, cyc, evc);
        chk("s5_cyc", cyc, 35);
        chk("s5_err", err1, 0);
        chk("s5_vec", vec1, 8);
        chk("s5_ev", evc, 0);

        // Reset mid-run
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("s5_mid_busy", busy1, 1);
        chk("s5_mid_vec", vec1, 2);
        reset = 1'b0;
        #1 chk_zero1("s5_rst");
        @(posedge clk); #1 reset = 1'b1;
        run(1'b1, 0, cyc, evc);
        chk("s5r_cyc", cyc, 35);
        chk("s5r_vec", vec1, 8);
        chk("s5r_err", err1, 0);
        chk("s5r_pass", pass1, 1);
        chk("s5r_ev", evc, 0);

        // SETTLE=0 variant
        run(1'b0, 0, cyc, evc);
        chk("s6_cyc", cyc, 27);
        chk("s6_vec", vec0, 8);
        chk("s6_err", err0, 0);
        chk("s6_pass", pass0, 1);
        chk("s6_ev", evc, 0);
        chk("s6_din", dut_in0, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
